// File: rtl/map_request_server.sv
// Map-lookup responder: owns the N*N maze RAM and serves round-robin arbitrated reads from NUM_REQ DDA requesters.
// Optional MAP_BOUNDS_CHECK_EN: out-of-range reads return a solid wall (4'hF) and raise sticky oob_error_out.
module map_request_server #(
    parameter int unsigned N       = 24,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = $clog2(N*N)
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        map_request_in,
    input  logic [NUM_REQ*ADDR_W-1:0] map_addra_in,
    output logic [3:0]                map_data_out,
    output logic [NUM_REQ-1:0]        map_data_valid_out,
    input  logic                      load_active_in,
    input  logic                      map_wr_en_in,
    input  logic [ADDR_W-1:0]         map_wr_addr_in,
    input  logic [3:0]                map_wr_data_in,
    output logic                      server_busy_out
`ifdef MAP_BOUNDS_CHECK_EN
    ,
    output logic                      oob_error_out
`endif
);

    localparam int unsigned DEPTH = N * N;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef MAP_BOUNDS_CHECK_EN
    localparam logic [3:0] OOB_DATA = 4'hF;
`else
    localparam logic [3:0] OOB_DATA = 4'h0;
`endif

    typedef enum logic [1:0] {SERVE, DRAIN, LOAD} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q [NUM_REQ];
    logic [ADDR_W-1:0]   addr_d [NUM_REQ];
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_oob_q, rd_oob_d;
    logic [NUM_REQ-1:0]  rd_vld_q, rd_vld_d;
    logic [3:0]          data_q, data_d;
    logic [NUM_REQ-1:0]  vld_q, vld_d;
    logic                busy_q, busy_d;
`ifdef MAP_BOUNDS_CHECK_EN
    logic                oob_q, oob_d;
`endif

    logic [NUM_REQ-1:0]  grant_c;
    logic [ADDR_W-1:0]   gaddr_c;
    logic [PTR_W-1:0]    sel_c;
    logic                found_c;
    logic                goob_c;
    logic                wr_fire_c;

    logic [3:0]          mem [DEPTH];

    // Round-robin grant, request capture, read pipeline and mode control
    always_comb begin
        state_d   = state_q;
        grant_c   = '0;
        gaddr_c   = '0;
        sel_c     = '0;
        found_c   = 1'b0;
        ptr_d     = ptr_q;

        if (state_q == SERVE) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                sel_c = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
                if (!found_c && pend_q[sel_c]) begin
                    found_c        = 1'b1;
                    grant_c[sel_c] = 1'b1;
                    gaddr_c        = addr_q[sel_c];
                    ptr_d          = PTR_W'((32'(sel_c) + 1) % NUM_REQ);
                end
            end
        end
        goob_c = found_c && (32'(gaddr_c) >= DEPTH);

        // A new pulse coinciding with this requester's grant re-arms it
        pend_d = (pend_q & ~grant_c) | map_request_in;
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_d[k] = map_request_in[k] ? map_addra_in[k*ADDR_W +: ADDR_W] : addr_q[k];
        end

        // Out-of-range grants never touch the RAM
        rd_vld_d  = grant_c;
        rd_oob_d  = goob_c;
        rd_addr_d = goob_c ? '0 : gaddr_c;

        vld_d  = rd_vld_q;
        data_d = data_q;
        if (|rd_vld_q) begin
            data_d = rd_oob_q ? OOB_DATA : mem[rd_addr_q];
        end

        busy_d = (|pend_d) | (|rd_vld_d);
`ifdef MAP_BOUNDS_CHECK_EN
        oob_d  = oob_q | goob_c;
`endif

        case (state_q)
            SERVE:   if (load_active_in) state_d = DRAIN;
            DRAIN:   if (rd_vld_q == '0) state_d = LOAD;
            LOAD:    if (!load_active_in) state_d = SERVE;
            default: state_d = SERVE;
        endcase

        wr_fire_c = (state_q == LOAD) && load_active_in && map_wr_en_in &&
                    (32'(map_wr_addr_in) < DEPTH);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= SERVE;
            pend_q    <= '0;
            ptr_q     <= '0;
            rd_addr_q <= '0;
            rd_oob_q  <= 1'b0;
            rd_vld_q  <= '0;
            data_q    <= '0;
            vld_q     <= '0;
            busy_q    <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                addr_q[k] <= '0;
            end
`ifdef MAP_BOUNDS_CHECK_EN
            oob_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            rd_addr_q <= rd_addr_d;
            rd_oob_q  <= rd_oob_d;
            rd_vld_q  <= rd_vld_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                addr_q[k] <= addr_d[k];
            end
`ifdef MAP_BOUNDS_CHECK_EN
            oob_q     <= oob_d;
`endif
        end
    end

    // Map RAM contents survive reset
    always_ff @(posedge pixel_clk_in) begin
        if (wr_fire_c) begin
            mem[map_wr_addr_in] <= map_wr_data_in;
        end
    end

    assign map_data_out       = data_q;
    assign map_data_valid_out = vld_q;
    assign server_busy_out    = busy_q;
`ifdef MAP_BOUNDS_CHECK_EN
    assign oob_error_out      = oob_q;
`endif

endmodule

// File: tb/tb_map_request_server.sv
// Self-checking bench for map_request_server: cycle-level reference model plus directed literal checks.
module tb_map_request_server;

    localparam int N     = 24;
    localparam int NR    = 2;
    localparam int AW    = 10;
    localparam int DEPTH = N * N;
`ifdef MAP_BOUNDS_CHECK_EN
    localparam logic [3:0] OOBV = 4'hF;
`else
    localparam logic [3:0] OOBV = 4'h0;
`endif

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR*AW-1:0] addra;
    logic [3:0]    data;
    logic [NR-1:0] valid;
    logic          load;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          busy;
`ifdef MAP_BOUNDS_CHECK_EN
    logic          oob;
`endif

    map_request_server #(.N(N), .NUM_REQ(NR), .ADDR_W(AW)) dut (
        .pixel_clk_in       (clk),
        .rst_n_in           (rst_n),
        .map_request_in     (req),
        .map_addra_in       (addra),
        .map_data_out       (data),
        .map_data_valid_out (valid),
        .load_active_in     (load),
        .map_wr_en_in       (wr_en),
        .map_wr_addr_in     (wr_addr),
        .map_wr_data_in     (wr_data),
        .server_busy_out    (busy)
`ifdef MAP_BOUNDS_CHECK_EN
        ,
        .oob_error_out      (oob)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 = serving, 1 = draining, 2 = loading
    bit         m_pend [NR];
    int         m_addr [NR];
    int         m_ptr;
    int         m_mode;
    logic [3:0] m_mem [DEPTH];
    int         exp_k [int];
    logic [3:0] exp_d [int];
    logic [3:0] m_data;
    bit         m_oob;
    int         cyc = 0;

    bit counting = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    int last_k = -1;
    int alt_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) begin
            m_pend[k] = 0;
            m_addr[k] = 0;
        end
        m_ptr  = 0;
        m_mode = 0;
        m_data = 4'h0;
        m_oob  = 0;
        exp_k.delete();
        exp_d.delete();
    endfunction

    function automatic void model_step();
        int gk;
        bit o;
        logic [3:0] d;
        gk = -1;
        if (m_mode == 0) begin
            for (int i = 0; i < NR; i++) begin
                if (gk < 0 && m_pend[(m_ptr + i) % NR]) gk = (m_ptr + i) % NR;
            end
        end
        if (gk >= 0) begin
            o = (m_addr[gk] >= DEPTH);
            d = o ? OOBV : m_mem[m_addr[gk]];
            if (o) m_oob = 1;
            exp_k[cyc + 2] = gk;
            exp_d[cyc + 2] = d;
            m_pend[gk] = 0;
            m_ptr = (gk + 1) % NR;
        end
        for (int k = 0; k < NR; k++) begin
            if (req[k]) begin
                m_pend[k] = 1;
                m_addr[k] = int'(addra[k*AW +: AW]);
            end
        end
        if (m_mode == 2 && load && wr_en && int'(wr_addr) < DEPTH) m_mem[wr_addr] = wr_data;
        case (m_mode)
            0: if (load) m_mode = 1;
            1: if (!exp_k.exists(cyc + 1)) m_mode = 2;
            default: if (!load) m_mode = 0;
        endcase
    endfunction

    // Compare every cycle against the model, then advance it with this cycle's inputs
    always @(negedge clk) begin
        logic [1:0] ev;
        if (!rst_n) model_reset();
        ev = 2'b00;
        if (exp_k.exists(cyc)) begin
            ev = 2'(1 << exp_k[cyc]);
            m_data = exp_d[cyc];
        end
        chk("valid", valid, ev);
        chk("data", data, m_data);
        chk("busy", busy, m_pend[0] || m_pend[1] || exp_k.exists(cyc + 1));
`ifdef MAP_BOUNDS_CHECK_EN
        chk("oob", oob, m_oob);
`endif
        if (counting && valid != 2'b00) begin
            int k;
            k = valid[1] ? 1 : 0;
            if (k == 0) cnt0++; else cnt1++;
            if (k == last_k) alt_viol++;
            last_k = k;
        end
        if (rst_n) model_step();
        cyc++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            req   = '0;
            wr_en = 1'b0;
        end
    endtask

    task automatic set_addr(input int k, input int a);
        addra[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step(1);
    endtask

    initial begin
        clk = 0; rst_n = 0; req = '0; addra = '0; load = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        step(2);
        rst_n = 1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
`ifdef MAP_BOUNDS_CHECK_EN
        chk("rst_oob", oob, 0);
`endif

        // Fill the whole map, then the two cells used by the directed cases
        load = 1;
        step(3);
        for (int a = 0; a < DEPTH; a++) wr(a, 4'((a * 5 + 1) % 16));
        wr(25, 4'h3);
        wr(50, 4'h7);
        wr(600, 4'h9);
        load = 0;
        step(2);

        // Single request: valid only at T+3
        req[0] = 1; set_addr(0, 25);
        step(1); chk("t1_v1", valid, 2'b00);
        step(1); chk("t1_v2", valid, 2'b00);
        step(1); chk("t1_v3", valid, 2'b01); chk("t1_d3", data, 4'h3);
        step(1); chk("t1_v4", valid, 2'b00); chk("t1_hold", data, 4'h3);

        // Requester 1 alone brings the pointer back to 0
        req[1] = 1; set_addr(1, 0);
        step(3); chk("ptr_v", valid, 2'b10); chk("ptr_d", data, 4'h1);
        step(1);

        // Simultaneous requests with pointer 0
        req = 2'b11; set_addr(0, 25); set_addr(1, 50);
        step(3); chk("t2_v3", valid, 2'b01); chk("t2_d3", data, 4'h3);
        step(1); chk("t2_v4", valid, 2'b10); chk("t2_d4", data, 4'h7);
        step(1); chk("t2_v5", valid, 2'b00); chk("t2_busy", busy, 0);

        // Both requesters pulse every cycle for 20 cycles
        counting = 1;
        for (int i = 0; i < 20; i++) begin
            req = 2'b11;
            set_addr(0, i * 7);
            set_addr(1, 575 - i * 3);
            step(1);
        end
        step(4);
        counting = 0;
        chk("b2b_cnt0", cnt0, 11);
        chk("b2b_cnt1", cnt1, 10);
        chk("b2b_alt", alt_viol, 0);
        chk("b2b_busy", busy, 0);

        // Load raised with two reads in flight (pointer is 1 here)
        req = 2'b11; set_addr(0, 25); set_addr(1, 50);
        step(2);
        load = 1;
        step(1); chk("t4_v3", valid, 2'b10); chk("t4_d3", data, 4'h7);
        step(1); chk("t4_v4", valid, 2'b01); chk("t4_d4", data, 4'h3);
        req[1] = 1; set_addr(1, 50);
        step(2); chk("t4_busy_load", busy, 1);
        wr(50, 4'hC);
        load = 0;
        step(1); chk("t4_f1", valid, 2'b00);
        step(1); chk("t4_f2", valid, 2'b00);
        step(1); chk("t4_f3", valid, 2'b10); chk("t4_fd", data, 4'hC);
        step(1);

        // Reset with two requests pending
        req = 2'b11; set_addr(0, 25); set_addr(1, 50);
        step(1);
        rst_n = 0;
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_valid", valid, 0);
        step(1);
        rst_n = 1;
        step(4); chk("rst2_quiet", valid, 2'b00);
        req[0] = 1; set_addr(0, 25);
        step(3); chk("rst2_v", valid, 2'b01); chk("rst2_ram", data, 4'h3);
        step(1);

        // Last in-range cell, then an out-of-range address
        req[1] = 1; set_addr(1, 575);
        step(3); chk("edge_v", valid, 2'b10); chk("edge_d", data, 4'hC);
        step(1);
`ifdef MAP_BOUNDS_CHECK_EN
        chk("oob_pre", oob, 0);
`endif
        req[0] = 1; set_addr(0, 600);
        step(3); chk("oob_v", valid, 2'b01); chk("oob_d", data, OOBV);
`ifdef MAP_BOUNDS_CHECK_EN
        chk("oob_set", oob, 1);
        step(3);
        chk("oob_sticky", oob, 1);
`endif
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
